// File: rtl/watch_set_control_pkg.sv
// Shared state and field-select encodings for the watch time-setting controller.
// A SET state's encoding equals the field code it selects.
package watch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_SET_SEC  = 2'b11
    } state_t;

    localparam logic [1:0] FLD_NONE = 2'b00;
    localparam logic [1:0] FLD_HOUR = 2'b01;
    localparam logic [1:0] FLD_MIN  = 2'b10;
    localparam logic [1:0] FLD_SEC  = 2'b11;

    function automatic logic [1:0] field_of(state_t s);
        case (s)
            ST_SET_HOUR: return FLD_HOUR;
            ST_SET_MIN:  return FLD_MIN;
            ST_SET_SEC:  return FLD_SEC;
            default:     return FLD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/watch_set_control_if.sv
// Button inputs and datapath-facing strobes of the time-setting controller.
// master = debouncer/datapath side, slave = the controller.
interface watch_set_control_if;

    logic       i_mode;
    logic       i_btn_set;
    logic       i_btn_up;
    logic       i_btn_down;
    logic [1:0] o_field_sel;
    logic       o_inc;
    logic       o_dec;
    logic       o_blink;
    logic       o_hold_time;
    logic       o_commit;

    modport master (
        output i_mode, i_btn_set, i_btn_up, i_btn_down,
        input  o_field_sel, o_inc, o_dec, o_blink, o_hold_time, o_commit
    );

    modport slave (
        input  i_mode, i_btn_set, i_btn_up, i_btn_down,
        output o_field_sel, o_inc, o_dec, o_blink, o_hold_time, o_commit
    );

endinterface

// File: rtl/watch_set_control_blink.sv
// Blink generator for the selected field: toggles every HALF_PERIOD enabled cycles,
// forced visible (1) while disabled or when restarted.
module blink_timer #(
    parameter int HALF_PERIOD = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_restart,
    output logic o_blink
);

    localparam int CNT_W = $clog2(HALF_PERIOD + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            o_blink <= 1'b1;
        end else if (i_restart || !i_en) begin
            cnt     <= '0;
            o_blink <= 1'b1;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            o_blink <= ~o_blink;
        end else begin
            cnt     <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/watch_set_control.sv
// Time-setting sequencer: walks hour/min/sec, issues inc/dec strobes, blink and hold.
// Optional inactivity auto-exit is built when WATCH_SET_TIMEOUT_EN is defined.
module watch_set_control
    import watch_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BLINK_HZ  = 2,
    parameter int TIMEOUT_S = 10
) (
    input  logic                clk,
    input  logic                reset,
    watch_set_control_if.slave  bus
);

    localparam int HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);

    if (TIMEOUT_S < 1 || BLINK_HZ < 1 || HALF_PERIOD < 1) begin : g_bad_cfg
        $error("watch_set_control: invalid CLK_HZ/BLINK_HZ/TIMEOUT_S");
    end

    state_t state, state_next;
    logic   inc_next, dec_next, commit_next;
    logic   inc_q, dec_q, commit_q;
    logic   restart, timeout_hit, set_active;

    assign set_active = (state != ST_IDLE);

`ifdef WATCH_SET_TIMEOUT_EN
    localparam int PRE_W = $clog2(CLK_HZ + 1);
    localparam int SEC_W = $clog2(TIMEOUT_S + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TIMEOUT_S - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [SEC_W-1:0] sec_cnt;

    // Fires on the cycle whose edge would complete TIMEOUT_S idle seconds.
    assign timeout_hit = set_active && (pre_cnt == PRE_LAST) && (sec_cnt == SEC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            sec_cnt <= '0;
        end else if (restart || !set_active) begin
            pre_cnt <= '0;
            sec_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            sec_cnt <= sec_cnt + SEC_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        inc_next    = 1'b0;
        dec_next    = 1'b0;
        commit_next = 1'b0;
        if (!set_active) begin
            if (bus.i_btn_set && bus.i_mode)
                state_next = ST_SET_HOUR;
        end else if (!bus.i_mode) begin
            state_next = ST_IDLE;
        end else if (timeout_hit) begin
            state_next  = ST_IDLE;
            commit_next = 1'b1;
        end else if (bus.i_btn_set) begin
            case (state)
                ST_SET_HOUR: state_next = ST_SET_MIN;
                ST_SET_MIN:  state_next = ST_SET_SEC;
                default: begin
                    state_next  = ST_IDLE;
                    commit_next = 1'b1;
                end
            endcase
        end else begin
            inc_next = bus.i_btn_up & ~bus.i_btn_down;
            dec_next = bus.i_btn_down & ~bus.i_btn_up;
        end
    end

    // Field entry/exit and accepted strobes restart the blink phase.
    assign restart = (state_next != state) || inc_next || dec_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state    <= state_next;
            inc_q    <= inc_next;
            dec_q    <= dec_next;
            commit_q <= commit_next;
        end
    end

    blink_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_blink (
        .clk       (clk),
        .reset     (reset),
        .i_en      (set_active),
        .i_restart (restart),
        .o_blink   (bus.o_blink)
    );

    assign bus.o_field_sel = field_of(state);
    assign bus.o_hold_time = set_active;
    assign bus.o_inc       = inc_q;
    assign bus.o_dec       = dec_q;
    assign bus.o_commit    = commit_q;

endmodule

// File: tb/tb_watch_set_control.sv
// Randomized and directed bench for watch_set_control with a scoreboard for strobes
// and a field/age reference model for levels; honours WATCH_SET_TIMEOUT_EN.
module tb_watch_set_control;

    localparam int CLK_HZ      = 100;
    localparam int BLINK_HZ    = 1;
    localparam int TIMEOUT_S   = 2;
    localparam int HALF        = CLK_HZ / (2 * BLINK_HZ);
    localparam int TIMEOUT_CYC = CLK_HZ * TIMEOUT_S;

    typedef struct {
        int         cyc;
        logic [2:0] kind;   // {inc, dec, commit}
        logic [1:0] field;
    } ev_t;

    logic clk;
    logic reset;
    watch_set_control_if bus();

    watch_set_control #(
        .CLK_HZ    (CLK_HZ),
        .BLINK_HZ  (BLINK_HZ),
        .TIMEOUT_S (TIMEOUT_S)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_en = 0;
    ev_t  sb_q[$];
    int   m_field = 0;   // 0 none, 1 hour, 2 min, 3 sec
    int   m_age   = 0;   // cycles since last field entry / accepted strobe
    ev_t  mon_e;
    logic [2:0] strobes;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_blink();
        if (m_field == 0) return 1;
        return ((m_age / HALF) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic push(input logic [2:0] kind, input logic [1:0] fld);
        ev_t e;
        e.cyc   = cyc + 1;
        e.kind  = kind;
        e.field = fld;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of buttons and advance the reference model to the post-edge state.
    task automatic step(input logic mode, input logic set, input logic up, input logic down);
        bit restart;
        restart = 0;
        @(negedge clk);
        bus.i_mode     = mode;
        bus.i_btn_set  = set;
        bus.i_btn_up   = up;
        bus.i_btn_down = down;
        if (m_field == 0) begin
            if (set && mode) begin
                m_field = 1;
                restart = 1;
            end
        end else if (!mode) begin
            m_field = 0;
            restart = 1;
        end
`ifdef WATCH_SET_TIMEOUT_EN
        else if (m_age + 1 == TIMEOUT_CYC) begin
            m_field = 0;
            push(3'b001, 2'b00);
            restart = 1;
        end
`endif
        else if (set) begin
            if (m_field == 3) begin
                m_field = 0;
                push(3'b001, 2'b00);
            end else begin
                m_field = m_field + 1;
            end
            restart = 1;
        end else if (up != down) begin
            push(up ? 3'b100 : 3'b010, 2'(m_field));
            restart = 1;
        end
        m_age = (restart || m_field == 0) ? 0 : m_age + 1;
    endtask

    task automatic tick(input logic mode, input logic set, input logic up, input logic down);
        step(mode, set, up, down);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        bus.i_btn_set  = 1'b0;
        bus.i_btn_up   = 1'b0;
        bus.i_btn_down = 1'b0;
        m_field        = 0;
        m_age          = 0;
        @(posedge clk);
        #2;
        check("rst_field_sel", bus.o_field_sel, 0);
        check("rst_hold", bus.o_hold_time, 0);
        check("rst_blink", bus.o_blink, 1);
        check("rst_commit", bus.o_commit, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compares levels every cycle, pops the scoreboard whenever a strobe is due or seen.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                check("mon_field_sel", bus.o_field_sel, m_field);
                check("mon_hold", bus.o_hold_time, (m_field != 0) ? 1 : 0);
                check("mon_blink", bus.o_blink, exp_blink());
                strobes = {bus.o_inc, bus.o_dec, bus.o_commit};
                if (strobes != 3'b000 || (sb_q.size() != 0 && sb_q[0].cyc <= cyc)) begin
                    if (sb_q.size() == 0) begin
                        check("strobe_unexpected", strobes, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("strobe_kind", strobes, mon_e.kind);
                        check("strobe_cycle", cyc, mon_e.cyc);
                        check("strobe_field", bus.o_field_sel, mon_e.field);
                    end
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        bus.i_mode     = 1'b1;
        bus.i_btn_set  = 1'b0;
        bus.i_btn_up   = 1'b0;
        bus.i_btn_down = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_field_sel", bus.o_field_sel, 0);
        check("init_hold", bus.o_hold_time, 0);
        check("init_blink", bus.o_blink, 1);
        check("init_strobes", {bus.o_inc, bus.o_dec, bus.o_commit}, 0);
        reset  = 1'b0;
        mon_en = 1;

        // Enter, two ups, one down.
        tick(1, 1, 0, 0);
        check("enter_field", bus.o_field_sel, 1);
        check("enter_hold", bus.o_hold_time, 1);
        tick(1, 0, 1, 0);
        check("up1_inc", bus.o_inc, 1);
        tick(1, 0, 1, 0);
        check("up2_inc", bus.o_inc, 1);
        tick(1, 0, 0, 1);
        check("down_dec", bus.o_dec, 1);
        check("down_inc", bus.o_inc, 0);
        tick(1, 0, 0, 0);
        check("strobe_width", bus.o_dec, 0);
        repeat (3) tick(1, 1, 0, 0);
        check("exit_commit", bus.o_commit, 1);

        // Set ignored in stopwatch mode.
        tick(0, 1, 0, 0);
        check("swmode_field", bus.o_field_sel, 0);
        check("swmode_hold", bus.o_hold_time, 0);

        // Four sets walk all fields and commit once.
        tick(1, 1, 0, 0);
        check("walk_hour", bus.o_field_sel, 1);
        tick(1, 1, 0, 0);
        check("walk_min", bus.o_field_sel, 2);
        tick(1, 1, 0, 0);
        check("walk_sec", bus.o_field_sel, 3);
        check("walk_no_commit", bus.o_commit, 0);
        tick(1, 1, 0, 0);
        check("walk_idle", bus.o_field_sel, 0);
        check("walk_commit", bus.o_commit, 1);
        tick(1, 0, 0, 0);
        check("walk_commit_width", bus.o_commit, 0);

        // Conflicting buttons in SET_MIN, then abort from SET_SEC.
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 0, 1, 1);
        check("updown_strobes", {bus.o_inc, bus.o_dec}, 0);
        check("updown_field", bus.o_field_sel, 2);
        tick(1, 1, 1, 0);
        check("setup_field", bus.o_field_sel, 3);
        check("setup_inc", bus.o_inc, 0);
        tick(0, 0, 0, 0);
        check("abort_field", bus.o_field_sel, 0);
        check("abort_commit", bus.o_commit, 0);

        // Blink phase in SET_HOUR.
        tick(1, 1, 0, 0);
        for (int k = 1; k <= 120; k++) begin
            tick(1, 0, 0, 0);
            if (k == 49)  check("blink_k49", bus.o_blink, 1);
            if (k == 50)  check("blink_k50", bus.o_blink, 0);
            if (k == 99)  check("blink_k99", bus.o_blink, 0);
            if (k == 100) check("blink_k100", bus.o_blink, 1);
        end
        tick(1, 0, 1, 0);
        check("blink_after_up", bus.o_blink, 1);
        for (int k = 1; k <= 50; k++) begin
            tick(1, 0, 0, 0);
            if (k == 49) check("blink_up_k49", bus.o_blink, 1);
            if (k == 50) check("blink_up_k50", bus.o_blink, 0);
        end
        tick(0, 0, 0, 0);

        // Reset while in SET_MIN.
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        check("pre_reset_field", bus.o_field_sel, 2);
        do_reset();

        // Inactivity in SET_HOUR.
        tick(1, 1, 0, 0);
        repeat (TIMEOUT_CYC - 1) tick(1, 0, 0, 0);
        check("idle_before_limit", bus.o_field_sel, 1);
        tick(1, 0, 0, 0);
`ifdef WATCH_SET_TIMEOUT_EN
        check("timeout_field", bus.o_field_sel, 0);
        check("timeout_commit", bus.o_commit, 1);
`else
        check("no_timeout_field", bus.o_field_sel, 1);
        check("no_timeout_commit", bus.o_commit, 0);
`endif
        tick(0, 0, 0, 0);

        // Random button traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        repeat (3) tick(0, 0, 0, 0);
        check("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
